// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
// master = requester / memory side, slave = the encoder itself.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [25:0]       in_imm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm,
    input  in_ready, im_we, im_addr, im_wdata, count, full, err
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm,
    output in_ready, im_we, im_addr, im_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs a mnemonic index plus operand fields into a 32-bit MIPS word and
// writes consecutive words into instruction memory behind a fill pointer.
module instr_encoder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned STOP_ON_ERR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  instr_encoder_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] P_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {FILL, FULL, HALT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_full;
  logic              r_err;

  logic        w_accept;
  logic        w_legal;
  logic        w_itype;
  logic        w_jtype;
  logic [5:0]  w_op;
  logic [5:0]  w_func;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;
  logic [31:0] w_word;

  assign bus.in_ready = (r_state == FILL) & ~rst & ~clr;
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Unused fields are zeroed per instruction rather than passed through.
  always_comb begin
    w_legal = 1'b1;
    w_itype = 1'b0;
    w_jtype = 1'b0;
    w_op    = '0;
    w_func  = '0;
    w_rs    = bus.in_rs;
    w_rt    = bus.in_rt;
    w_rd    = bus.in_rd;
    w_sh    = '0;
    unique case (bus.in_mnem)
      6'd0:  w_func = 6'h21;
      6'd1:  w_func = 6'h23;
      6'd2:  w_func = 6'h2A;
      6'd3:  w_func = 6'h24;
      6'd4:  w_func = 6'h27;
      6'd5:  w_func = 6'h25;
      6'd6:  w_func = 6'h26;
      6'd7:  begin w_func = 6'h00; w_rs = '0; w_sh = bus.in_shamt; end
      6'd8:  begin w_func = 6'h02; w_rs = '0; w_sh = bus.in_shamt; end
      6'd9:  w_func = 6'h2B;
      6'd10: begin w_func = 6'h09; w_rt = '0; end
      6'd11: begin w_func = 6'h08; w_rt = '0; w_rd = '0; end
      6'd12: w_func = 6'h04;
      6'd13: begin w_func = 6'h03; w_rs = '0; w_sh = bus.in_shamt; end
      6'd14: w_func = 6'h07;
      6'd15: w_func = 6'h06;
      6'd16: begin w_itype = 1'b1; w_op = 6'h09; end
      6'd17: begin w_itype = 1'b1; w_op = 6'h04; end
      6'd18: begin w_itype = 1'b1; w_op = 6'h05; end
      6'd19: begin w_itype = 1'b1; w_op = 6'h23; end
      6'd20: begin w_itype = 1'b1; w_op = 6'h2B; end
      6'd21: begin w_itype = 1'b1; w_op = 6'h0F; w_rs = '0; end
      6'd22: begin w_itype = 1'b1; w_op = 6'h0A; end
      6'd23: begin w_itype = 1'b1; w_op = 6'h0B; end
      6'd24: begin w_itype = 1'b1; w_op = 6'h01; w_rt = 5'd1; end
      6'd25: begin w_itype = 1'b1; w_op = 6'h01; w_rt = '0; end
      6'd26: begin w_itype = 1'b1; w_op = 6'h07; w_rt = '0; end
      6'd27: begin w_itype = 1'b1; w_op = 6'h06; w_rt = '0; end
      6'd28: begin w_itype = 1'b1; w_op = 6'h20; end
      6'd29: begin w_itype = 1'b1; w_op = 6'h24; end
      6'd30: begin w_itype = 1'b1; w_op = 6'h28; end
      6'd31: begin w_itype = 1'b1; w_op = 6'h0C; end
      6'd32: begin w_itype = 1'b1; w_op = 6'h0D; end
      6'd33: begin w_itype = 1'b1; w_op = 6'h0E; end
      6'd34: begin w_jtype = 1'b1; w_op = 6'h02; end
      6'd35: begin w_jtype = 1'b1; w_op = 6'h03; end
      default: w_legal = 1'b0;
    endcase
    if (w_jtype)
      w_word = {w_op, bus.in_imm};
    else if (w_itype)
      w_word = {w_op, w_rs, w_rt, bus.in_imm[15:0]};
    else
      w_word = {6'd0, w_rs, w_rt, w_rd, w_sh, w_func};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= FILL;
      r_ptr   <= P_BASE;
      r_addr  <= P_BASE;
      r_count <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= w_word;
          r_count <= r_count + (ADDR_W+1)'(1);
          // Pointer parks on the last word instead of wrapping.
          if (r_ptr == P_LAST) begin
            r_state <= FULL;
            r_full  <= 1'b1;
          end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
          end
        end else begin
          r_err <= 1'b1;
          if (STOP_ON_ERR != 0)
            r_state <= HALT;
        end
      end
    end
  end

  assign bus.im_we    = r_we;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = r_wdata;
  assign bus.count    = r_count;
  assign bus.full     = r_full;
  assign bus.err      = r_err;
endmodule
